// File: rtl/div_unit.sv
// div_unit -- iterative 32-bit integer divider for DIV/DIVU.
// One restoring radix-2 step per cycle over a 64-bit partial-remainder /
// quotient register. The start cycle is followed by 32 RUN cycles and one
// DONE cycle, so ready rises 33 cycles after start.
// Optional build macro: DIV_ZERO_FAST_EN -- a start with a zero divisor
// bypasses the iteration and reaches DONE one cycle after start.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        busy,
  output logic        ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] rq_q, rq_d;        // {partial remainder, dividend/quotient}
  logic [31:0] divisor_q, divisor_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        signed_q, signed_d;
  logic        zero_q, zero_d;    // divisor was zero
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;

  // Operand magnitudes and signs as seen at the start cycle.
  logic        opa_neg, opb_neg;
  logic [31:0] opa_mag, opb_mag;

  // One restoring step and the sign-corrected result of that step.
  logic [32:0] shifted_rem;
  logic [32:0] diff;
  logic [63:0] step;
  logic [31:0] q_mag, r_mag;
  logic [31:0] q_fix, r_fix;

  // Absolute values of the incoming operands (only in signed mode).
  always_comb begin
    opa_neg = signed_div & opa[31];
    opb_neg = signed_div & opb[31];
    opa_mag = opa_neg ? (~opa + 32'd1) : opa;
    opb_mag = opb_neg ? (~opb + 32'd1) : opb;
  end

  // Restoring step: shift left, trial-subtract the divisor, keep or restore.
  // The shifted remainder needs 33 bits because it can reach 2*divisor-1.
  always_comb begin
    shifted_rem = rq_q[63:31];
    diff        = shifted_rem - {1'b0, divisor_q};
    if (!diff[32]) begin
      step = {diff[31:0], rq_q[30:0], 1'b1};
    end else begin
      step = {rq_q[62:0], 1'b0};
    end
    q_mag = step[31:0];
    r_mag = step[63:32];
    // Quotient sign follows the operand signs, remainder follows the dividend.
    // 0x80000000 / -1 wraps back to 0x80000000 through the negation.
    q_fix = (signed_q && (sign_a_q ^ sign_b_q)) ? (~q_mag + 32'd1) : q_mag;
    r_fix = (signed_q && sign_a_q) ? (~r_mag + 32'd1) : r_mag;
    // A zero divisor leaves |opa| in the remainder half, which the sign fix
    // turns back into opa; only the quotient needs forcing.
    if (zero_q) begin
      q_fix = 32'hFFFF_FFFF;
    end
  end

  // Next-state, datapath load/step and handshake outputs.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rq_d        = rq_q;
    divisor_d   = divisor_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    signed_d    = signed_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy        = 1'b0;
    ready       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          busy      = 1'b1;
          rq_d      = {32'd0, opa_mag};
          divisor_d = opb_mag;
          sign_a_d  = opa_neg;
          sign_b_d  = opb_neg;
          signed_d  = signed_div;
          zero_d    = (opb == 32'd0);
          cnt_d     = 5'd0;
`ifdef DIV_ZERO_FAST_EN
          if (opb == 32'd0) begin
            state_d     = S_DONE;
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = opa;
          end else begin
            state_d = S_RUN;
          end
`else
          state_d = S_RUN;
`endif
        end
      end

      S_RUN: begin
        busy  = 1'b1;
        rq_d  = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d     = S_DONE;
          quotient_d  = q_fix;
          remainder_d = r_fix;
        end
      end

      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush annuls whatever is in flight and leaves the results untouched.
    if (flush) begin
      state_d     = S_IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      rq_q        <= 64'd0;
      divisor_q   <= 32'd0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      signed_q    <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rq_q        <= rq_d;
      divisor_q   <= divisor_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      signed_q    <= signed_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
